// File: rtl/axis_adder_injector.sv
// axis_adder_injector: sends operand packets A and B to the adder node, checks the returned sums and pulses DONE
module axis_adder_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int NUM_OPS    = 4,
    parameter int ADDER_ID   = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  START2,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [DEST_WIDTH-1:0] M_AXIS_TDEST,
    output logic                  M_AXIS_TUSER,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic                  DONE,
    output logic [15:0]           ERR_CNT,
    output logic [15:0]           PKT_CNT
);
    localparam int IW = $clog2(NUM_OPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_OPS - 1);
    localparam logic [DATA_WIDTH-1:0] OFS = DATA_WIDTH'('h100);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, RECV, FIN} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_k;
    logic [IW-1:0]         r_j;
    logic [TW-1:0]         r_tmo;
    logic                  r_pend;
    logic                  r_a_done;
    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_a_nxt;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_m_hs;
    logic                  w_s_hs;
    logic                  w_k_last;
    logic                  w_j_last;
    logic                  w_to_b;
    logic                  w_tmo_hit;
    logic [1:0]            w_nerr;
    logic [1:0]            w_inc;
    logic [16:0]           w_err_sum;

    // Operand/expectation arithmetic and handshake decode for the current transaction
    always_comb begin
        w_base    = DATA_WIDTH'(PKT_CNT) * DATA_WIDTH'(NUM_OPS);
        w_a_nxt   = w_base + DATA_WIDTH'(r_k + 1'b1);
        w_exp     = ((w_base + DATA_WIDTH'(r_j)) << 1) + OFS;
        w_m_hs    = M_AXIS_TVALID & M_AXIS_TREADY;
        w_s_hs    = S_AXIS_TVALID & S_AXIS_TREADY;
        w_k_last  = r_k == LAST;
        w_j_last  = r_j == LAST;
        w_to_b    = (r_state == SEND_A) & (r_pend | START2) & (r_a_done | (w_m_hs & w_k_last));
        w_tmo_hit = r_tmo == TW'(TIMEOUT - 1);
        // a flit can carry a data mismatch and, independently, a TLAST/length error
        w_nerr    = {1'b0, S_AXIS_TDATA != w_exp} + {1'b0, S_AXIS_TLAST != w_j_last};
        w_inc     = w_s_hs ? w_nerr : {1'b0, w_tmo_hit};
        w_err_sum = {1'b0, ERR_CNT} + {15'b0, w_inc};
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_j           <= '0;
            r_tmo         <= '0;
            r_pend        <= 1'b0;
            r_a_done      <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TDEST  <= DEST_WIDTH'(ADDER_ID);
            M_AXIS_TUSER  <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
            DONE          <= 1'b0;
            ERR_CNT       <= '0;
            PKT_CNT       <= '0;
        end else begin
            DONE <= 1'b0;
            if (START2 && r_state != IDLE && r_state != FIN)
                r_pend <= 1'b1;
            case (r_state)
                IDLE: if (START) begin
                    r_state       <= SEND_A;
                    r_k           <= '0;
                    r_a_done      <= 1'b0;
                    M_AXIS_TDATA  <= w_base;
                    M_AXIS_TUSER  <= 1'b0;
                    M_AXIS_TLAST  <= LAST == '0;
                    M_AXIS_TVALID <= 1'b1;
                end
                SEND_A, SEND_B: begin
                    if (w_to_b) begin
                        r_state       <= SEND_B;
                        r_k           <= '0;
                        r_pend        <= 1'b0;
                        r_a_done      <= 1'b0;
                        M_AXIS_TDATA  <= w_base + OFS;
                        M_AXIS_TUSER  <= 1'b1;
                        M_AXIS_TLAST  <= LAST == '0;
                        M_AXIS_TVALID <= 1'b1;
                    end else if (w_m_hs && !w_k_last) begin
                        r_k          <= r_k + 1'b1;
                        M_AXIS_TDATA <= M_AXIS_TUSER ? w_a_nxt + OFS : w_a_nxt;
                        M_AXIS_TLAST <= (r_k + 1'b1) == LAST;
                    end else if (w_m_hs) begin
                        M_AXIS_TVALID <= 1'b0;
                        M_AXIS_TLAST  <= 1'b0;
                        M_AXIS_TUSER  <= 1'b0;
                        if (r_state == SEND_A)
                            r_a_done <= 1'b1;
                        else begin
                            r_state       <= RECV;
                            r_j           <= '0;
                            r_tmo         <= '0;
                            S_AXIS_TREADY <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    ERR_CNT <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                    r_tmo   <= w_s_hs ? '0 : r_tmo + 1'b1;
                    if (w_s_hs)
                        r_j <= r_j + 1'b1;
                    if (w_s_hs ? (S_AXIS_TLAST || w_j_last) : w_tmo_hit) begin
                        r_state       <= FIN;
                        S_AXIS_TREADY <= 1'b0;
                        DONE          <= 1'b1;
                        PKT_CNT       <= PKT_CNT + 1'b1;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_adder_injector.sv
// tb_axis_adder_injector: scoreboard bench with an adder-node model answering the injector
module tb_axis_adder_injector;
    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int TMO = 64;

    logic          CLK = 0, RST_N = 0, START = 0, START2 = 0;
    logic          M_AXIS_TREADY = 0, S_AXIS_TLAST = 0, S_AXIS_TVALID = 0;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic [DW-1:0] M_AXIS_TDATA;
    logic [3:0]    M_AXIS_TDEST;
    logic          M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID, S_AXIS_TREADY, DONE;
    logic [15:0]   ERR_CNT, PKT_CNT;

    int n_chk = 0, n_pass = 0;
    int bp = 0, done_cnt = 0, exp_err = 0, exp_pkt = 0, cyc = 0, a0_cyc = 0, bl_cyc = 0;
    logic [33:0] exp_q[$];
    logic [31:0] done_q[$];
    logic [31:0] rx_a[$], rx_b[$];

    axis_adder_injector #(.DATA_WIDTH(DW), .DEST_WIDTH(4), .NUM_OPS(N), .ADDER_ID(1), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START2(START2),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TDEST(M_AXIS_TDEST), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .DONE(DONE), .ERR_CNT(ERR_CNT), .PKT_CNT(PKT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tvalid"}, M_AXIS_TVALID, 0);
        check({tag, " tlast"}, M_AXIS_TLAST, 0);
        check({tag, " tuser"}, M_AXIS_TUSER, 0);
        check({tag, " tdata"}, M_AXIS_TDATA, 0);
        check({tag, " tdest"}, M_AXIS_TDEST, 1);
        check({tag, " s_tready"}, S_AXIS_TREADY, 0);
        check({tag, " done"}, DONE, 0);
        check({tag, " err_cnt"}, ERR_CNT, 0);
        check({tag, " pkt_cnt"}, PKT_CNT, 0);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(posedge CLK);
        #1;
        M_AXIS_TREADY = (bp != 0) ? 1'($urandom % 2) : 1'b1;
    end

    // operand-side monitor: flit order/content, hold-while-stalled, and handoff into RECV
    initial begin
        logic        stall, chk_rdy;
        logic [33:0] held, got, e;
        stall = 0; chk_rdy = 0; held = '0;
        forever begin
            @(negedge CLK);
            got = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
            if (!RST_N) begin
                stall = 0; chk_rdy = 0;
            end else begin
                if (chk_rdy) check("s_tready after B last", S_AXIS_TREADY, 1);
                chk_rdy = 0;
                if (stall) check("hold while stalled", {M_AXIS_TVALID, got}, {1'b1, held});
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected flit: got %0h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("flit {user,last,data}", got, e);
                        check("tdest", M_AXIS_TDEST, 1);
                    end
                    if (M_AXIS_TUSER) rx_b.push_back(M_AXIS_TDATA);
                    else begin
                        if (rx_a.size() == 0) a0_cyc = cyc;
                        rx_a.push_back(M_AXIS_TDATA);
                    end
                    if (M_AXIS_TUSER && M_AXIS_TLAST) begin
                        bl_cyc = cyc;
                        chk_rdy = 1;
                    end
                end
                stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                held = got;
            end
        end
    end

    // DONE monitor: pulse width and counters against the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            if (RST_N && DONE) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected DONE: got 1 expected 0");
                end else begin
                    e = done_q.pop_front();
                    @(negedge CLK);
                    check("done one cycle", DONE, 0);
                    check("err_cnt", ERR_CNT, e[31:16]);
                    check("pkt_cnt", PKT_CNT, e[15:0]);
                end
                done_cnt++;
            end
        end
    end

    // adder-node model: mode 0 correct sums, 1 corrupt R_2, 2 TLAST on flit 1, 3 silent
    task automatic respond(input int mode);
        int w, n, cnt, g;
        logic [31:0] d;
        w = 0;
        while (rx_b.size() < N && w < 200) begin
            @(posedge CLK);
            w++;
        end
        check("B packet collected", rx_b.size(), N);
        #1;
        if (mode == 3) begin
            cnt = 0; w = 0;
            while (w < 4 * TMO) begin
                @(negedge CLK);
                if (DONE) break;
                if (S_AXIS_TREADY) cnt++;
                w++;
            end
            n_chk++;
            if (DONE && cnt >= TMO && cnt <= TMO + 1) n_pass++;
            else $display("FAIL timeout: done=%0d after %0d ready cycles, expected done after %0d", DONE, cnt, TMO);
        end else begin
            n = (mode == 2) ? 2 : N;
            for (int i = 0; i < n; i++) begin
                g = (bp != 0) ? int'($urandom % 3) : 0;
                repeat (g) begin
                    @(posedge CLK);
                    #1;
                end
                d = rx_a.pop_front() + rx_b.pop_front();
                if (mode == 1 && i == 2) d = d ^ 32'h4;
                S_AXIS_TVALID = 1;
                S_AXIS_TDATA = d;
                S_AXIS_TLAST = (i == n - 1);
                w = 0;
                @(negedge CLK);
                while (!S_AXIS_TREADY && w < 200) begin
                    @(negedge CLK);
                    w++;
                end
                if (!S_AXIS_TREADY) begin
                    n_chk++;
                    $display("FAIL s_tready wait: got 0 expected 1");
                end
                @(posedge CLK);
                #1;
                S_AXIS_TVALID = 0;
                S_AXIS_TLAST = 0;
            end
            @(negedge CLK);
            check("done after final rx", DONE, 1);
        end
        rx_a.delete();
        rx_b.delete();
    endtask

    task automatic launch(output int p);
        p = exp_pkt;
        for (int k = 0; k < N; k++) exp_q.push_back({1'b0, 1'(k == N - 1), 32'(p * N + k)});
        for (int k = 0; k < N; k++) exp_q.push_back({1'b1, 1'(k == N - 1), 32'(p * N + k + 'h100)});
        @(posedge CLK);
        #1 START = 1;
        @(posedge CLK);
        #1 START = 0;
        START2 = 1;
        check("tvalid one cycle after start", M_AXIS_TVALID, 1);
        check("A_0 one cycle after start", M_AXIS_TDATA, 32'(p * N));
        @(posedge CLK);
        #1 START2 = 0;
    endtask

    task automatic run_txn(input int mode);
        int p, d0, w;
        d0 = done_cnt;
        exp_pkt++;
        if (mode != 0) exp_err++;
        done_q.push_back({16'(exp_err), 16'(exp_pkt)});
        exp_pkt--;
        launch(p);
        exp_pkt++;
        respond(mode);
        w = 0;
        while (done_cnt == d0 && w < 100) begin
            @(posedge CLK);
            w++;
        end
        check("transaction completed", done_cnt, d0 + 1);
        repeat (2) @(posedge CLK);
        check("all operand flits sent", exp_q.size(), 0);
        if (bp == 0) check("no bubble A->B", bl_cyc - a0_cyc, 2 * N - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, w;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1 RST_N = 1;
        for (int t = 0; t < 10; t++) run_txn(0);
        check("pkt_cnt after ten", PKT_CNT, 10);
        check("err_cnt after ten", ERR_CNT, 0);
        bp = 1;
        for (int t = 0; t < 6; t++) run_txn(0);
        bp = 0;
        run_txn(1);
        run_txn(2);
        run_txn(3);
        check("err_cnt after error cases", ERR_CNT, 3);
        launch(p);
        w = 0;
        while (rx_b.size() < 1 && w < 50) begin
            @(posedge CLK);
            w++;
        end
        check("in SEND_B flit 1", {M_AXIS_TVALID, M_AXIS_TUSER}, 2'b11);
        #2 RST_N = 0;
        #1;
        check_reset_outputs("mid-packet reset");
        exp_q.delete();
        done_q.delete();
        rx_a.delete();
        rx_b.delete();
        exp_err = 0;
        exp_pkt = 0;
        @(posedge CLK);
        #1 RST_N = 1;
        run_txn(0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
